// File: rtl/matrix_loader.sv
// rtl/matrix_loader.sv - gathers two size x size matrices element-by-element and presents them as a pair
module matrix_loader #(
    parameter int size   = 1,
    parameter int length = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [length-1:0]             in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [size*size*length-1:0]   out_first,
    output logic [size*size*length-1:0]   out_second,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [3:0]                    elem_idx,
    output logic                          loading_b
);
    localparam int N = size * size;
    localparam int W = N * length;
    localparam logic [3:0] LAST_IDX = 4'(N - 1);

    typedef enum logic [1:0] {LOAD_A, LOAD_B, HOLD} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_idx;
    logic [3:0]    w_idx_nxt;
    logic [W-1:0]  r_mat_a;
    logic [W-1:0]  r_mat_b;
    logic          r_out_valid;
    logic          w_xfer;
    logic          w_last;

    assign in_ready   = (r_state != HOLD);
    assign w_xfer     = in_valid & in_ready;
    assign w_last     = (r_idx == LAST_IDX);
    assign out_first  = r_mat_a;
    assign out_second = r_mat_b;
    assign out_valid  = r_out_valid;
    assign elem_idx   = r_idx;
    assign loading_b  = (r_state == LOAD_B);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= LOAD_A;
            r_idx       <= 4'd0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_out_valid <= (w_state_nxt == HOLD);
        end
    end

    // flush overrides both the element transfer and the output handshake
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        if (flush) begin
            w_state_nxt = LOAD_A;
            w_idx_nxt   = 4'd0;
        end else begin
            unique case (r_state)
                LOAD_A, LOAD_B: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            w_idx_nxt   = 4'd0;
                            w_state_nxt = (r_state == LOAD_A) ? LOAD_B : HOLD;
                        end else begin
                            w_idx_nxt = r_idx + 4'd1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        w_state_nxt = LOAD_A;
                        w_idx_nxt   = 4'd0;
                    end
                end
                default: begin
                    w_state_nxt = LOAD_A;
                    w_idx_nxt   = 4'd0;
                end
            endcase
        end
    end

    // storage is only cleared by reset; elements persist across handshakes and flushes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mat_a <= '0;
            r_mat_b <= '0;
        end else if (w_xfer && !flush) begin
            for (int k = 0; k < N; k++) begin
                if (r_idx == 4'(k)) begin
                    if (r_state == LOAD_A)
                        r_mat_a[k*length +: length] <= in_data;
                    else
                        r_mat_b[k*length +: length] <= in_data;
                end
            end
        end
    end
endmodule

// File: tb/tb_matrix_loader.sv
// tb/tb_matrix_loader.sv - directed self-checking bench for matrix_loader at size 1, 2 and 3
module tb_matrix_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;

    logic        rdy1, rdy2, rdy3;
    logic        ov1, ov2, ov3;
    logic        lb1, lb2, lb3;
    logic [3:0]  idx1, idx2, idx3;
    logic [7:0]  a1, b1;
    logic [31:0] a2, b2;
    logic [71:0] a3, b3;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    matrix_loader #(.size(1), .length(8)) u1 (
        .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy1), .out_first(a1), .out_second(b1), .out_valid(ov1),
        .out_ready(out_ready), .elem_idx(idx1), .loading_b(lb1));

    matrix_loader #(.size(2), .length(8)) u2 (
        .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy2), .out_first(a2), .out_second(b2), .out_valid(ov2),
        .out_ready(out_ready), .elem_idx(idx2), .loading_b(lb2));

    matrix_loader #(.size(3), .length(8)) u3 (
        .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy3), .out_first(a3), .out_second(b3), .out_valid(ov3),
        .out_ready(out_ready), .elem_idx(idx3), .loading_b(lb3));

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // inputs change on the falling edge; outputs are sampled on the falling edge after the rising one
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic feed(input logic [7:0] d);
        in_data = d; in_valid = 1'b1;
        tick();
    endtask

    initial begin
        logic [7:0] s2 [8];
        int         xfers;
        s2 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0A, 8'h0B, 8'h0C, 8'h0D};

        @(negedge clk);
        check("rst_in_ready", rdy2, 1);
        check("rst_out_valid", ov2, 0);
        check("rst_out_first", a2, 0);
        check("rst_out_second", b2, 0);
        check("rst_elem_idx", idx2, 0);
        check("rst_loading_b", lb2, 0);
        rst = 1'b0;

        // size 2 continuous stream
        for (int i = 0; i < 7; i++) feed(s2[i]);
        check("s2_pre_valid", ov2, 0);
        check("s2_pre_idx", idx2, 3);
        check("s2_pre_lb", lb2, 1);
        feed(s2[7]);
        check("s2_valid", ov2, 1);
        check("s2_first", a2, 32'h04030201);
        check("s2_second", b2, 32'h0D0C0B0A);
        check("s2_in_ready_hold", rdy2, 0);

        // stall in HOLD with in_valid still asserted
        in_data = 8'hFF; in_valid = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_in_ready", rdy2, 0);
            check("hold_valid", ov2, 1);
            check("hold_first", a2, 32'h04030201);
            check("hold_second", b2, 32'h0D0C0B0A);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0; in_valid = 1'b0;
        check("ack_valid", ov2, 0);
        check("ack_in_ready", rdy2, 1);
        check("ack_idx", idx2, 0);
        check("ack_persist", a2, 32'h04030201);

        // size 3 with in_valid toggling
        do_reset();
        xfers = 0;
        for (int c = 0; c < 36; c++) begin
            in_valid = (c % 2 == 0);
            in_data  = 8'h10 + 8'(xfers);
            if (in_valid && rdy3) xfers++;
            tick();
            if (in_valid && xfers == 8) check("s3_lb_before9", lb3, 0);
            if (in_valid && xfers == 9) check("s3_lb_after9", lb3, 1);
        end
        in_valid = 1'b0;
        check("s3_xfers", xfers, 18);
        check("s3_valid", ov3, 1);
        check("s3_elem9", a3[71:64], 8'h18);
        check("s3_first", a3, 72'h181716151413121110);
        check("s3_second", b3, 72'h21201F1E1D1C1B1A19);

        // flush colliding with a transfer at B index 2
        do_reset();
        feed(8'h11); feed(8'h12); feed(8'h13); feed(8'h14);
        feed(8'h21); feed(8'h22);
        check("fl_pre_idx", idx2, 2);
        check("fl_pre_lb", lb2, 1);
        in_data = 8'h99; in_valid = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_idx", idx2, 0);
        check("fl_lb", lb2, 0);
        check("fl_valid", ov2, 0);
        check("fl_in_ready", rdy2, 1);
        check("fl_second", b2, 32'h00002221);
        check("fl_first", a2, 32'h14131211);

        // async reset while holding a complete pair
        for (int i = 0; i < 8; i++) feed(s2[i]);
        in_valid = 1'b0;
        check("ar_pre_valid", ov2, 1);
        #1 rst = 1'b1;
        #1;
        check("ar_valid", ov2, 0);
        check("ar_first", a2, 0);
        check("ar_second", b2, 0);
        check("ar_idx", idx2, 0);
        check("ar_in_ready", rdy2, 1);
        #1 rst = 1'b0;
        @(negedge clk);

        // size 1 two-transfer pair
        do_reset();
        feed(8'h7F);
        check("s1_lb", lb1, 1);
        check("s1_mid_valid", ov1, 0);
        feed(8'h81);
        in_valid = 1'b0;
        check("s1_valid", ov1, 1);
        check("s1_first", a1, 8'h7F);
        check("s1_second", b1, 8'h81);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
